rom_port_arbiter: RTL and testbench

Two-requester arbiter that time-shares the single `genrom` read port between the core's instruction-fetch path (F) and its operand/data path (D). It sequences each access through a three-state controller, drives the ROM address, extra-width and bounds lines from the granted requester, and returns the ROM data and error back to that requester with a one-cycle valid pulse. It sits between `core` and `genrom`, replacing the direct `mem_*` connection.

---
 rtl/rom_port_arbiter.sv | 173 +++++++++++++++++
 tb/tb_rom_port_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/rom_port_arbiter.sv
// Two-requester arbiter sharing one ROM read port between fetch (F) and data (D) paths.
// Round-robin on ties; each access is IDLE/CAPTURE -> ISSUE -> CAPTURE with a registered valid pulse.
module rom_port_arbiter #(
    parameter int MEM_ADDR  = 6,
    parameter int MEM_EXTRA = 4,
    localparam int AW = MEM_ADDR + 1,
    localparam int DW = (2 ** MEM_EXTRA) * 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 f_req,
    input  logic [AW-1:0]        f_addr,
    input  logic [MEM_EXTRA-1:0] f_extra,
    input  logic [AW-1:0]        f_lower,
    input  logic [AW-1:0]        f_upper,
    input  logic                 d_req,
    input  logic [AW-1:0]        d_addr,
    input  logic [MEM_EXTRA-1:0] d_extra,
    input  logic [AW-1:0]        d_lower,
    input  logic [AW-1:0]        d_upper,
    output logic                 f_gnt,
    output logic                 f_valid,
    output logic [DW-1:0]        f_data,
    output logic                 f_error,
    output logic                 d_gnt,
    output logic                 d_valid,
    output logic [DW-1:0]        d_data,
    output logic                 d_error,
    output logic [AW-1:0]        mem_addr,
    output logic [MEM_EXTRA-1:0] mem_extra,
    output logic [AW-1:0]        mem_lower_bound,
    output logic [AW-1:0]        mem_upper_bound,
    input  logic [DW-1:0]        mem_data,
    input  logic                 mem_error,
    output logic                 busy
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE} state_t;
    localparam logic OWN_F = 1'b0;
    localparam logic OWN_D = 1'b1;

    state_t               state_q, state_d;
    logic                 owner_q, owner_d;
    logic                 last_q, last_d;
    logic                 f_gnt_q, f_gnt_d, d_gnt_q, d_gnt_d;
    logic                 f_valid_q, f_valid_d, d_valid_q, d_valid_d;
    logic                 f_error_q, f_error_d, d_error_q, d_error_d;
    logic [DW-1:0]        f_data_q, f_data_d, d_data_q, d_data_d;
    logic [AW-1:0]        mem_addr_q, mem_addr_d;
    logic [MEM_EXTRA-1:0] mem_extra_q, mem_extra_d;
    logic [AW-1:0]        mem_lower_q, mem_lower_d;
    logic [AW-1:0]        mem_upper_q, mem_upper_d;

    logic any_req;
    logic winner;
    logic arb;

    assign any_req = f_req | d_req;
    // Lone requester wins outright; on a tie the side that did not win last time goes.
    assign winner  = (f_req && d_req) ? ~last_q : d_req;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        f_gnt_d     = 1'b0;
        d_gnt_d     = 1'b0;
        f_valid_d   = 1'b0;
        d_valid_d   = 1'b0;
        f_error_d   = f_error_q;
        d_error_d   = d_error_q;
        f_data_d    = f_data_q;
        d_data_d    = d_data_q;
        mem_addr_d  = mem_addr_q;
        mem_extra_d = mem_extra_q;
        mem_lower_d = mem_lower_q;
        mem_upper_d = mem_upper_q;
        arb         = 1'b0;

        case (state_q)
            S_IDLE: arb = 1'b1;
            S_ISSUE: state_d = S_CAPTURE;
            S_CAPTURE: begin
                arb = 1'b1;
                if (owner_q == OWN_F) begin
                    f_data_d  = mem_data;
                    f_error_d = mem_error;
                    f_valid_d = 1'b1;
                end else begin
                    d_data_d  = mem_data;
                    d_error_d = mem_error;
                    d_valid_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Arbitration shares the CAPTURE edge so back-to-back accesses take two cycles.
        if (arb) begin
            if (any_req) begin
                state_d = S_ISSUE;
                owner_d = winner;
                last_d  = winner;
                if (winner == OWN_F) begin
                    f_gnt_d     = 1'b1;
                    mem_addr_d  = f_addr;
                    mem_extra_d = f_extra;
                    mem_lower_d = f_lower;
                    mem_upper_d = f_upper;
                end else begin
                    d_gnt_d     = 1'b1;
                    mem_addr_d  = d_addr;
                    mem_extra_d = d_extra;
                    mem_lower_d = d_lower;
                    mem_upper_d = d_upper;
                end
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_F;
            last_q      <= OWN_D;
            f_gnt_q     <= 1'b0;
            d_gnt_q     <= 1'b0;
            f_valid_q   <= 1'b0;
            d_valid_q   <= 1'b0;
            f_error_q   <= 1'b0;
            d_error_q   <= 1'b0;
            f_data_q    <= '0;
            d_data_q    <= '0;
            mem_addr_q  <= '0;
            mem_extra_q <= '0;
            mem_lower_q <= '0;
            mem_upper_q <= '1;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            f_gnt_q     <= f_gnt_d;
            d_gnt_q     <= d_gnt_d;
            f_valid_q   <= f_valid_d;
            d_valid_q   <= d_valid_d;
            f_error_q   <= f_error_d;
            d_error_q   <= d_error_d;
            f_data_q    <= f_data_d;
            d_data_q    <= d_data_d;
            mem_addr_q  <= mem_addr_d;
            mem_extra_q <= mem_extra_d;
            mem_lower_q <= mem_lower_d;
            mem_upper_q <= mem_upper_d;
        end
    end

    assign f_gnt           = f_gnt_q;
    assign d_gnt           = d_gnt_q;
    assign f_valid         = f_valid_q;
    assign d_valid         = d_valid_q;
    assign f_error         = f_error_q;
    assign d_error         = d_error_q;
    assign f_data          = f_data_q;
    assign d_data          = d_data_q;
    assign mem_addr        = mem_addr_q;
    assign mem_extra       = mem_extra_q;
    assign mem_lower_bound = mem_lower_q;
    assign mem_upper_bound = mem_upper_q;
    assign busy            = (state_q != S_IDLE);

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter with a registered ROM model (byte a = a + 0x0F,
// zero data and error=1 when the address lies outside the bounds window).
module tb_rom_port_arbiter;

    localparam int MEM_ADDR  = 6;
    localparam int MEM_EXTRA = 4;
    localparam int AW = MEM_ADDR + 1;
    localparam int DW = (2 ** MEM_EXTRA) * 8;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 f_req = 1'b0, d_req = 1'b0;
    logic [AW-1:0]        f_addr = '0, d_addr = '0;
    logic [MEM_EXTRA-1:0] f_extra = '0, d_extra = '0;
    logic [AW-1:0]        f_lower = '0, d_lower = '0;
    logic [AW-1:0]        f_upper = 7'h7F, d_upper = 7'h7F;
    logic                 f_gnt, d_gnt, f_valid, d_valid, f_error, d_error, busy;
    logic [DW-1:0]        f_data, d_data;
    logic [AW-1:0]        mem_addr, mem_lower_bound, mem_upper_bound;
    logic [MEM_EXTRA-1:0] mem_extra;
    logic [DW-1:0]        mem_data = '0;
    logic                 mem_error = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    rom_port_arbiter #(.MEM_ADDR(MEM_ADDR), .MEM_EXTRA(MEM_EXTRA)) dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_extra(f_extra), .f_lower(f_lower), .f_upper(f_upper),
        .d_req(d_req), .d_addr(d_addr), .d_extra(d_extra), .d_lower(d_lower), .d_upper(d_upper),
        .f_gnt(f_gnt), .f_valid(f_valid), .f_data(f_data), .f_error(f_error),
        .d_gnt(d_gnt), .d_valid(d_valid), .d_data(d_data), .d_error(d_error),
        .mem_addr(mem_addr), .mem_extra(mem_extra),
        .mem_lower_bound(mem_lower_bound), .mem_upper_bound(mem_upper_bound),
        .mem_data(mem_data), .mem_error(mem_error), .busy(busy)
    );

    always #5 clk = ~clk;

    // ROM samples the address lines on every rising edge.
    always @(posedge clk) begin
        if (mem_addr < mem_lower_bound || mem_addr > mem_upper_bound) begin
            mem_data  <= '0;
            mem_error <= 1'b1;
        end else begin
            mem_data  <= {{(DW-8){1'b0}}, 8'(mem_addr + 7'd15)};
            mem_error <= 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        // Reset values
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("rst_f_gnt", f_gnt, 0);
        chk("rst_d_gnt", d_gnt, 0);
        chk("rst_valids", {f_valid, d_valid}, 0);
        chk("rst_errors", {f_error, d_error}, 0);
        chk("rst_f_data", f_data, 0);
        chk("rst_d_data", d_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_extra", mem_extra, 0);
        chk("rst_mem_lower", mem_lower_bound, 0);
        chk("rst_mem_upper", mem_upper_bound, 7'h7F);

        // Single fetch of byte 17
        f_req = 1'b1; f_addr = 7'd17; f_extra = '0; f_lower = 7'h00; f_upper = 7'h7F;
        tick();
        chk("sf_f_gnt", f_gnt, 1);
        chk("sf_d_gnt", d_gnt, 0);
        chk("sf_busy", busy, 1);
        chk("sf_mem_addr", mem_addr, 17);
        f_req = 1'b0;
        tick();
        chk("sf_gnt_drop", f_gnt, 0);
        chk("sf_issue_valid", f_valid, 0);
        chk("sf_busy2", busy, 1);
        tick();
        chk("sf_f_valid", f_valid, 1);
        chk("sf_f_data", f_data, 8'h20);
        chk("sf_f_error", f_error, 0);
        chk("sf_d_untouched", {d_valid, d_error, d_gnt}, 0);
        chk("sf_d_data", d_data, 0);
        chk("sf_idle", busy, 0);
        tick();
        chk("sf_valid_drop", f_valid, 0);
        chk("sf_data_hold", f_data, 8'h20);

        // Tie from reset: F first, D on F's capture edge
        pulse_reset();
        f_req = 1'b1; f_addr = 7'd5;
        d_req = 1'b1; d_addr = 7'd9; d_lower = 7'h00; d_upper = 7'h7F;
        tick();
        chk("tie_f_gnt", f_gnt, 1);
        chk("tie_d_gnt0", d_gnt, 0);
        f_req = 1'b0;
        tick();
        tick();
        chk("tie_f_valid", f_valid, 1);
        chk("tie_f_data", f_data, 8'h14);
        chk("tie_d_gnt", d_gnt, 1);
        chk("tie_mem_addr", mem_addr, 9);
        d_req = 1'b0;
        tick();
        chk("tie_d_gnt_drop", d_gnt, 0);
        tick();
        chk("tie_d_valid", d_valid, 1);
        chk("tie_d_data", d_data, 8'h18);
        chk("tie_f_valid_drop", f_valid, 0);
        chk("tie_f_hold", f_data, 8'h14);
        chk("tie_idle", busy, 0);

        // Continuous contention: F,D,F,D,... one grant every 2 cycles
        f_addr = 7'd1; d_addr = 7'd2;
        f_req = 1'b1; d_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("cc_f_gnt%0d", i), f_gnt, (i % 2 == 0) ? 1 : 0);
            chk($sformatf("cc_d_gnt%0d", i), d_gnt, (i % 2 == 1) ? 1 : 0);
            chk($sformatf("cc_busy%0d", i), busy, 1);
            if (i > 0)
                chk($sformatf("cc_valid%0d", i), {f_valid, d_valid}, (i % 2 == 1) ? 2'b10 : 2'b01);
            if (i == 7) begin
                f_req = 1'b0; d_req = 1'b0;
            end
            tick();
            chk($sformatf("cc_gap%0d", i), {f_gnt, d_gnt, f_valid, d_valid}, 0);
            chk($sformatf("cc_busy_gap%0d", i), busy, 1);
        end
        tick();
        chk("cc_last_d_valid", d_valid, 1);
        chk("cc_last_d_data", d_data, 8'h11);
        chk("cc_f_data", f_data, 8'h10);
        chk("cc_idle", busy, 0);

        // Out-of-bounds D access reports the ROM error
        d_req = 1'b1; d_addr = 7'h50; d_lower = 7'h00; d_upper = 7'h3F;
        tick();
        chk("be_d_gnt", d_gnt, 1);
        chk("be_mem_upper", mem_upper_bound, 7'h3F);
        chk("be_mem_addr", mem_addr, 7'h50);
        d_req = 1'b0;
        tick();
        tick();
        chk("be_d_valid", d_valid, 1);
        chk("be_d_error", d_error, 1);
        chk("be_f_valid", f_valid, 0);
        chk("be_f_error", f_error, 0);

        // Reset while the fetch is in ISSUE
        f_req = 1'b1; f_addr = 7'd17; f_lower = 7'h00; f_upper = 7'h7F;
        tick();
        chk("ri_f_gnt", f_gnt, 1);
        f_req = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("ri_gnt_clr", f_gnt, 0);
        chk("ri_busy", busy, 0);
        chk("ri_f_data", f_data, 0);
        chk("ri_mem_upper", mem_upper_bound, 7'h7F);
        tick();
        chk("ri_no_valid1", f_valid, 0);
        reset = 1'b0;
        tick();
        chk("ri_no_valid2", f_valid, 0);
        chk("ri_f_data2", f_data, 0);
        f_req = 1'b1; f_addr = 7'd3;
        d_req = 1'b1; d_addr = 7'd4; d_upper = 7'h7F;
        tick();
        chk("ri_f_first", {f_gnt, d_gnt}, 2'b10);
        f_req = 1'b0;
        tick();
        tick();
        chk("ri_f_valid", f_valid, 1);
        chk("ri_f_data3", f_data, 8'h12);
        chk("ri_d_gnt", d_gnt, 1);
        d_req = 1'b0;
        tick();
        tick();
        chk("ri_d_valid", d_valid, 1);
        chk("ri_d_data", d_data, 8'h13);
        chk("ri_d_error", d_error, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
